// File: rtl/booth_pkg.sv
// ----------------------------------------------------------------------------
// booth_pkg
// Shared types and helpers for the radix-4 Booth multiplier slice.
//   state_t  : controller states (IDLE, EXEC, DONE)
//   recode_t : radix-4 Booth partial-product selection
//   steps()  : number of radix-4 steps needed for a given operand width
// ----------------------------------------------------------------------------
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    PP_ZERO,
    PP_POS1,
    PP_POS2,
    PP_NEG1,
    PP_NEG2
  } recode_t;

  // Operands are widened by two bits, so one extra step covers the
  // extension bits.
  function automatic int steps(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_r4_multiplier_if.sv
// ----------------------------------------------------------------------------
// booth_r4_multiplier_if
// Operation handshake and operand/result bus of the radix-4 Booth multiplier.
//   op_start     : start request (controller -> multiplier)
//   op_clear     : synchronous return to IDLE (controller -> multiplier)
//   op_signed    : 1 = two's-complement operands, 0 = unsigned
//   multiplier   : operand B, WIDTH bits
//   multiplicand : operand A, WIDTH bits
//   op_busy      : high while an operation executes
//   op_done      : high while a finished product is held
//   result       : 2*WIDTH-bit product, valid while op_done is high
// The master modport is used by the controller, the slave modport by the
// multiplier.
// ----------------------------------------------------------------------------
interface booth_r4_multiplier_if #(
  parameter int WIDTH = 64
);

  logic                 op_start;
  logic                 op_clear;
  logic                 op_signed;
  logic [WIDTH-1:0]     multiplier;
  logic [WIDTH-1:0]     multiplicand;
  logic                 op_busy;
  logic                 op_done;
  logic [2*WIDTH-1:0]   result;

  modport master (
    output op_start, op_clear, op_signed, multiplier, multiplicand,
    input  op_busy, op_done, result
  );

  modport slave (
    input  op_start, op_clear, op_signed, multiplier, multiplicand,
    output op_busy, op_done, result
  );

endinterface

// File: rtl/booth_r4_recoder.sv
// ----------------------------------------------------------------------------
// booth_r4_recoder
// Combinational radix-4 Booth recoder.
//   triplet : {b[2i+1], b[2i], b[2i-1]} of the multiplier
//   code    : partial-product selection {0, +A, +2A, -A, -2A}
// ----------------------------------------------------------------------------
module booth_r4_recoder
  import booth_pkg::*;
(
  input  logic [2:0] triplet,
  output recode_t    code
);

  // Standard radix-4 table: the triplet's value is -2*b1 + b0 + b(-1).
  always_comb begin
    code = PP_ZERO;
    case (triplet)
      3'b001, 3'b010: code = PP_POS1;
      3'b011:         code = PP_POS2;
      3'b100:         code = PP_NEG2;
      3'b101, 3'b110: code = PP_NEG1;
      default:        code = PP_ZERO;
    endcase
  end

endmodule

// File: rtl/booth_r4_multiplier.sv
// ----------------------------------------------------------------------------
// booth_r4_multiplier
// Sequential radix-4 Booth multiplier retiring two multiplier bits per cycle.
// The operands are extended to WIDTH+2 bits (signed or unsigned per
// op_signed) and the product is ready WIDTH/2+1 cycles after start.
//   clk    : rising-edge clock
//   reset  : synchronous, active-high reset
//   bus    : booth_r4_multiplier_if.slave (handshake, operands, result)
// Optional build macro BOOTH_EARLY_TERM_EN: finish as soon as the
// unconsumed multiplier bits are all-zero or all-one, shifting the
// remaining distance in one cycle. Results are identical either way.
// ----------------------------------------------------------------------------
module booth_r4_multiplier
  import booth_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  booth_r4_multiplier_if.slave   bus
);

  localparam int IW = WIDTH + 2;
  localparam int N  = steps(WIDTH);
  localparam int CW = $clog2(N + 1);

  state_t             state, state_next;
  logic               load, step, finish, last_step;
  logic [IW:0]        acc;
  logic [IW-1:0]      mplr;
  logic [IW-1:0]      mcand;
  logic               q_m1;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] result_r;

  recode_t            code;
  logic [IW:0]        a_ext;
  logic [IW:0]        pp;
  logic [IW:0]        sum;
  logic [IW:0]        acc_next;
  logic [IW-1:0]      mplr_next;
  logic [2*WIDTH-1:0] prod_next;

  booth_r4_recoder u_recoder (
    .triplet ({mplr[1:0], q_m1}),
    .code    (code)
  );

  assign a_ext = {mcand[IW-1], mcand};

  always_comb begin
    pp = '0;
    case (code)
      PP_POS1: pp = a_ext;
      PP_POS2: pp = a_ext << 1;
      PP_NEG1: pp = -a_ext;
      PP_NEG2: pp = -(a_ext << 1);
      default: pp = '0;
    endcase
  end

  // One step: add the partial product, then arithmetic-shift the
  // {acc, mplr, q(-1)} chain right by two.
  assign sum       = acc + pp;
  assign acc_next  = {{2{sum[IW]}}, sum[IW:2]};
  assign mplr_next = {sum[1:0], mplr[IW-1:2]};
  assign last_step = (count == CW'(N - 1));

`ifdef BOOTH_EARLY_TERM_EN
  logic [IW-1:0] mplr_orig;
  logic [IW-1:0] window;
  logic [2*IW:0] shifted;
  logic          uniform;

  // After step k the unconsumed bits are mplr_orig[IW-1:2k-1]; if they
  // are uniform every remaining recode is zero, so only shifts remain.
  always_comb begin
    window  = IW'($signed(mplr_orig) >>> (2 * (int'(count) + 1) - 1));
    uniform = (window == '0) || (&window);
    finish  = last_step || uniform;
    shifted = $signed({acc_next, mplr_next}) >>> (2 * (N - (int'(count) + 1)));
    prod_next = shifted[2*WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mplr_orig <= '0;
    end else if (load) begin
      mplr_orig <= bus.op_signed ? {{2{bus.multiplier[WIDTH-1]}}, bus.multiplier}
                                 : {2'b00, bus.multiplier};
    end
  end
`else
  assign finish    = last_step;
  assign prod_next = {acc_next[WIDTH-3:0], mplr_next};
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and datapath strobes; op_clear outranks op_start.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.op_clear && bus.op_start) begin
          state_next = EXEC;
          load       = 1'b1;
        end
      end
      EXEC: begin
        if (bus.op_clear) begin
          state_next = IDLE;
        end else begin
          step = 1'b1;
          if (finish) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (bus.op_clear) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch extended operands on start, advance one step per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc   <= '0;
      mplr  <= '0;
      mcand <= '0;
      q_m1  <= 1'b0;
      count <= '0;
    end else if (load) begin
      acc   <= '0;
      q_m1  <= 1'b0;
      count <= '0;
      mplr  <= bus.op_signed ? {{2{bus.multiplier[WIDTH-1]}}, bus.multiplier}
                             : {2'b00, bus.multiplier};
      mcand <= bus.op_signed ? {{2{bus.multiplicand[WIDTH-1]}}, bus.multiplicand}
                             : {2'b00, bus.multiplicand};
    end else if (step) begin
      acc   <= acc_next;
      mplr  <= mplr_next;
      q_m1  <= mplr[1];
      count <= count + 1'b1;
    end
  end

  // The result register only changes on DONE entry and is zero otherwise.
  always_ff @(posedge clk) begin
    if (reset || bus.op_clear) begin
      result_r <= '0;
    end else if (step && finish) begin
      result_r <= prod_next;
    end
  end

  assign bus.op_busy = (state == EXEC);
  assign bus.op_done = (state == DONE);
  assign bus.result  = result_r;

endmodule

// File: tb/tb_booth_r4_multiplier.sv
// ----------------------------------------------------------------------------
// tb_booth_r4_multiplier
// Self-checking bench for booth_r4_multiplier at WIDTH=64. Expected
// latency depends on BOOTH_EARLY_TERM_EN, which the bench honours too.
// ----------------------------------------------------------------------------
module tb_booth_r4_multiplier;

  localparam int W         = 64;
  localparam int LAT_LIMIT = 100;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  booth_r4_multiplier_if #(.WIDTH(W)) bus ();

  booth_r4_multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected latency: smallest k whose unconsumed window is uniform when
  // early termination is built in, otherwise always 33.
  function automatic int exp_lat(input logic [63:0] b, input logic sgn);
`ifdef BOOTH_EARLY_TERM_EN
    logic [65:0] e;
    logic        ok;
    e = sgn ? {{2{b[63]}}, b} : {2'b00, b};
    for (int k = 1; k < 33; k++) begin
      ok = 1'b1;
      for (int i = 2 * k - 1; i < 66; i++) begin
        if (e[i] !== e[65]) ok = 1'b0;
      end
      if (ok) return k;
    end
    return 33;
`else
    if (sgn === 1'bx || b === 'x) return 33;
    return 33;
`endif
  endfunction

  // Reference product computed with a plain wide multiply.
  function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                           input logic sgn);
    logic [127:0] ea, eb;
    ea = sgn ? {{64{a[63]}}, a} : {64'b0, a};
    eb = sgn ? {{64{b[63]}}, b} : {64'b0, b};
    return ea * eb;
  endfunction

  // Starts an operation, scrambles the operands after acceptance, and waits
  // (bounded) for op_done. lat counts edges after the accepting edge.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic sgn,
                        output int lat, output logic busy0, output logic [127:0] res);
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.op_signed    = sgn;
    bus.op_start     = 1'b1;
    @(posedge clk); #1;
    bus.op_start     = 1'b0;
    bus.multiplicand = ~a;
    bus.multiplier   = ~b;
    bus.op_signed    = ~sgn;
    busy0 = bus.op_busy;
    lat = 0;
    while (bus.op_done !== 1'b1 && lat < LAT_LIMIT) begin
      @(posedge clk); #1;
      lat++;
    end
    res = bus.result;
  endtask

  task automatic clear_op();
    bus.op_clear = 1'b1;
    @(posedge clk); #1;
    bus.op_clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checks += 3;
    if (bus.op_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", bus.op_busy); end
    if (bus.op_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b want 0", bus.op_done); end
    if (bus.result !== 128'h0) begin errors++; $display("[TB] FAIL reset_result: got %h want 0", bus.result); end
    clear_op();
    checks += 3;
    if (bus.op_busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_clear_busy: got %b want 0", bus.op_busy); end
    if (bus.op_done !== 1'b0) begin errors++; $display("[TB] FAIL idle_clear_done: got %b want 0", bus.op_done); end
    if (bus.result !== 128'h0) begin errors++; $display("[TB] FAIL idle_clear_result: got %h want 0", bus.result); end
  endtask

  task automatic test_signed();
    int           lat;
    logic         busy0;
    logic [127:0] res;
    int           want_lat;
`ifdef BOOTH_EARLY_TERM_EN
    want_lat = 4;
`else
    want_lat = 33;
`endif
    run_op(64'hFFFF_FFFF_FFFF_FFF9, 64'h64, 1'b1, lat, busy0, res);
    checks += 3;
    if (busy0 !== 1'b1) begin errors++; $display("[TB] FAIL signed_busy_at_start: got %b want 1", busy0); end
    if (lat != want_lat) begin errors++; $display("[TB] FAIL signed_latency: got %0d want %0d", lat, want_lat); end
    if (res !== 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FD44) begin
      errors++; $display("[TB] FAIL signed_result: got %h want ffff..fd44", res);
    end
    repeat (3) @(posedge clk);
    #1;
    checks += 3;
    if (bus.op_done !== 1'b1) begin errors++; $display("[TB] FAIL done_hold: got %b want 1", bus.op_done); end
    if (bus.op_busy !== 1'b0) begin errors++; $display("[TB] FAIL done_busy: got %b want 0", bus.op_busy); end
    if (bus.result !== 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FD44) begin
      errors++; $display("[TB] FAIL done_result_hold: got %h", bus.result);
    end
    clear_op();
    checks += 3;
    if (bus.op_busy !== 1'b0) begin errors++; $display("[TB] FAIL clear_busy: got %b want 0", bus.op_busy); end
    if (bus.op_done !== 1'b0) begin errors++; $display("[TB] FAIL clear_done: got %b want 0", bus.op_done); end
    if (bus.result !== 128'h0) begin errors++; $display("[TB] FAIL clear_result: got %h want 0", bus.result); end
  endtask

  task automatic test_mode();
    int           lat;
    logic         busy0;
    logic [127:0] res;
    run_op('1, '1, 1'b0, lat, busy0, res);
    checks++;
    if (res !== 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001) begin
      errors++; $display("[TB] FAIL unsigned_all_ones: got %h want fffffffffffffffe0000000000000001", res);
    end
    clear_op();
    run_op('1, '1, 1'b1, lat, busy0, res);
    checks++;
    if (res !== 128'h1) begin errors++; $display("[TB] FAIL signed_all_ones: got %h want 1", res); end
    clear_op();
  endtask

  task automatic test_back_to_back();
    int           lat;
    logic         busy0;
    logic         seen_done;
    logic [127:0] res;
    // Abandon an operation 10 cycles into EXEC.
    bus.multiplicand = 64'h7;
    bus.multiplier   = 64'h5555_5555_5555_5555;
    bus.op_signed    = 1'b0;
    bus.op_start     = 1'b1;
    @(posedge clk); #1;
    bus.op_start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    checks += 2;
    if (bus.op_busy !== 1'b1) begin errors++; $display("[TB] FAIL exec_busy: got %b want 1", bus.op_busy); end
    if (bus.result !== 128'h0) begin errors++; $display("[TB] FAIL exec_result: got %h want 0", bus.result); end
    clear_op();
    checks += 2;
    if (bus.op_busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b want 0", bus.op_busy); end
    if (bus.op_done !== 1'b0) begin errors++; $display("[TB] FAIL abort_done: got %b want 0", bus.op_done); end
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.op_done === 1'b1) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0) begin errors++; $display("[TB] FAIL abort_no_done: got %b want 0", seen_done); end

    run_op(64'd6, 64'd3, 1'b0, lat, busy0, res);
    checks += 2;
    if (res !== 128'd18) begin errors++; $display("[TB] FAIL six_times_three: got %h want 12", res); end
    if (lat != exp_lat(64'd3, 1'b0)) begin
      errors++; $display("[TB] FAIL six_times_three_lat: got %0d want %0d", lat, exp_lat(64'd3, 1'b0));
    end
    clear_op();

    // op_start pulsed during EXEC and DONE must be ignored.
    bus.multiplicand = 64'h7;
    bus.multiplier   = 64'h5555_5555_5555_5555;
    bus.op_signed    = 1'b0;
    bus.op_start     = 1'b1;
    @(posedge clk); #1;
    bus.op_start = 1'b0;
    lat = 0;
    repeat (3) begin @(posedge clk); #1; lat++; end
    bus.multiplicand = 64'h1;
    bus.multiplier   = 64'h1;
    bus.op_start     = 1'b1;
    @(posedge clk); #1;
    lat++;
    bus.op_start = 1'b0;
    while (bus.op_done !== 1'b1 && lat < LAT_LIMIT) begin
      @(posedge clk); #1;
      lat++;
    end
    checks += 2;
    if (lat != exp_lat(64'h5555_5555_5555_5555, 1'b0)) begin
      errors++; $display("[TB] FAIL start_in_exec_lat: got %0d want %0d", lat, exp_lat(64'h5555_5555_5555_5555, 1'b0));
    end
    if (bus.result !== 128'h2_5555_5555_5555_5553) begin
      errors++; $display("[TB] FAIL start_in_exec_result: got %h want 25555555555555553", bus.result);
    end
    bus.op_start = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.op_start = 1'b0;
    checks += 3;
    if (bus.op_done !== 1'b1) begin errors++; $display("[TB] FAIL start_in_done_done: got %b want 1", bus.op_done); end
    if (bus.op_busy !== 1'b0) begin errors++; $display("[TB] FAIL start_in_done_busy: got %b want 0", bus.op_busy); end
    if (bus.result !== 128'h2_5555_5555_5555_5553) begin
      errors++; $display("[TB] FAIL start_in_done_result: got %h", bus.result);
    end
    clear_op();

    // op_start together with op_clear in IDLE: clear wins.
    bus.op_start = 1'b1;
    bus.op_clear = 1'b1;
    @(posedge clk); #1;
    bus.op_start = 1'b0;
    bus.op_clear = 1'b0;
    checks += 2;
    if (bus.op_busy !== 1'b0) begin errors++; $display("[TB] FAIL start_clear_busy: got %b want 0", bus.op_busy); end
    @(posedge clk); #1;
    if (bus.op_busy !== 1'b0 || bus.op_done !== 1'b0) begin
      errors++; $display("[TB] FAIL start_clear_idle: got busy=%b done=%b want 0 0", bus.op_busy, bus.op_done);
    end
  endtask

  task automatic test_early_term();
    int           lat;
    logic         busy0;
    logic [127:0] res;
    int           want_lat;
`ifdef BOOTH_EARLY_TERM_EN
    want_lat = 1;
`else
    want_lat = 33;
`endif
    run_op(64'h1234_5678_9ABC_DEF0, 64'h0, 1'b1, lat, busy0, res);
    checks += 2;
    if (res !== 128'h0) begin errors++; $display("[TB] FAIL zero_mplr_result: got %h want 0", res); end
    if (lat != want_lat) begin errors++; $display("[TB] FAIL zero_mplr_lat: got %0d want %0d", lat, want_lat); end
    clear_op();
    run_op(64'd5, '1, 1'b1, lat, busy0, res);
    checks += 2;
    if (res !== 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFB) begin
      errors++; $display("[TB] FAIL minus_one_result: got %h want ffff..fffb", res);
    end
    if (lat != want_lat) begin errors++; $display("[TB] FAIL minus_one_lat: got %0d want %0d", lat, want_lat); end
    clear_op();
  endtask

  task automatic test_random();
    int           lat;
    logic         busy0;
    logic [127:0] res;
    logic [127:0] want;
    logic [63:0]  a, b;
    int           sh;
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 200; i++) begin
        a  = {$urandom, $urandom};
        b  = {$urandom, $urandom};
        sh = $urandom_range(63, 0);
        case (i % 4)
          1: b = b >> sh;
          2: b = ~(b >> sh);
          3: a = a >> sh;
          default: ;
        endcase
        want = ref_mul(a, b, m[0]);
        run_op(a, b, m[0], lat, busy0, res);
        checks += 2;
        if (res !== want) begin
          errors++; $display("[TB] FAIL random_result: a=%h b=%h s=%0d got %h want %h", a, b, m, res, want);
        end
        if (lat != exp_lat(b, m[0])) begin
          errors++; $display("[TB] FAIL random_lat: b=%h s=%0d got %0d want %0d", b, m, lat, exp_lat(b, m[0]));
        end
        clear_op();
      end
    end
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    reset            = 1'b1;
    bus.op_start     = 1'b0;
    bus.op_clear     = 1'b0;
    bus.op_signed    = 1'b0;
    bus.multiplier   = '0;
    bus.multiplicand = '0;
    test_reset();
    test_signed();
    test_mode();
    test_back_to_back();
    test_early_term();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
